// File: rtl/mips_multicycle_controller.sv
// mips_multicycle_controller
//
// Moore-style control unit for a multi-cycle MIPS datapath. The datapath has
// one shared memory and one ALU. Each instruction is sequenced over several
// states. Memory accesses can stall on a ready handshake. An unsupported
// opcode is flagged in DECODE and abandoned there.
//
// Parameters:
//   BNE_EN        - 1: opcode 6'b000101 (bne) is decoded; 0: it is illegal
//   USE_MEM_READY - 0: mem_ready is ignored and treated as always 1
//
// Ports:
//   clk, rst      - clock (rising edge) and synchronous active-high reset
//   op_code[5:0]  - IR[31:26], held stable by the IR after FETCH completes
//   zero          - ALU zero flag, used by BRANCH
//   mem_ready     - memory access completes in the current cycle
//   ir_w, pc_en   - IR write enable and qualified PC write enable
//   i_or_d        - memory address mux (0 = PC, 1 = ALUOut)
//   mem_w, reg_w  - memory and register-file write enables
//   reg_dest      - write register mux (1 = rd, 0 = rt)
//   mem_to_reg    - write data mux (1 = memory data, 0 = ALUOut)
//   alu_src_a     - ALU A mux (0 = PC, 1 = register A)
//   alu_src_b     - ALU B mux (00 = B, 01 = 4, 10 = sign-ext imm, 11 = imm<<2)
//   pc_src        - next-PC mux (00 = ALU result, 01 = ALUOut, 10 = jump)
//   alu_op        - ALU decoder control (00 = add, 01 = sub, 10 = funct)
//   instr_done    - one-cycle pulse in the last cycle of every instruction
//   illegal_op    - one-cycle pulse in DECODE for an unsupported opcode
//   state[3:0]    - current state code, for debug
module mips_multicycle_controller #(
  parameter bit BNE_EN        = 1'b1,
  parameter bit USE_MEM_READY = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] op_code,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       ir_w,
  output logic       pc_en,
  output logic       i_or_d,
  output logic       mem_w,
  output logic       reg_w,
  output logic       reg_dest,
  output logic       mem_to_reg,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] pc_src,
  output logic [1:0] alu_op,
  output logic       instr_done,
  output logic       illegal_op,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMRD    = 4'd3,
    MEMWB    = 4'd4,
    MEMWR    = 4'd5,
    EXECUTE  = 4'd6,
    ALUWB    = 4'd7,
    BRANCH   = 4'd8,
    ADDIEXEC = 4'd9,
    ADDIWB   = 4'd10,
    JUMP     = 4'd11
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b00_0000;
  localparam logic [5:0] OP_J     = 6'b00_0010;
  localparam logic [5:0] OP_BEQ   = 6'b00_0100;
  localparam logic [5:0] OP_BNE   = 6'b00_0101;
  localparam logic [5:0] OP_ADDI  = 6'b00_1000;
  localparam logic [5:0] OP_LW    = 6'b10_0011;
  localparam logic [5:0] OP_SW    = 6'b10_1011;

  // The register is a plain 4-bit vector rather than the enum type. Codes
  // 12-15 have no enum name, and keeping the register plain lets those codes
  // be represented and recovered through the default branch.
  logic [3:0] state_q;
  state_t     next_state;
  logic       ready;
  logic       op_is_bne;

  assign ready     = USE_MEM_READY ? mem_ready : 1'b1;
  assign op_is_bne = BNE_EN && (op_code == OP_BNE);
  assign state     = rst ? 4'd0 : state_q;

  // State register. Reset lands on FETCH at the reset edge. This abandons any
  // instruction in flight before it reaches a write-back state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= FETCH;
    end else begin
      state_q <= next_state;
    end
  end

  // Next-state and control outputs. Every output depends on the current state
  // only. The exceptions are the ready-qualified enables, the branch decision
  // and the illegal-opcode flag. All outputs are forced low while reset is
  // held, so nothing is written in the reset cycle.
  always_comb begin
    next_state = FETCH;
    ir_w       = 1'b0;
    pc_en      = 1'b0;
    i_or_d     = 1'b0;
    mem_w      = 1'b0;
    reg_w      = 1'b0;
    reg_dest   = 1'b0;
    mem_to_reg = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'b00;
    pc_src     = 2'b00;
    alu_op     = 2'b00;
    instr_done = 1'b0;
    illegal_op = 1'b0;

    case (state_q)
      FETCH: begin
        alu_src_b  = 2'b01;
        ir_w       = ready;
        pc_en      = ready;
        next_state = ready ? DECODE : FETCH;
      end
      DECODE: begin
        // Precompute the branch target into ALUOut while the opcode is decoded.
        alu_src_b = 2'b11;
        case (op_code)
          OP_LW, OP_SW: next_state = MEMADR;
          OP_RTYPE:     next_state = EXECUTE;
          OP_BEQ:       next_state = BRANCH;
          OP_ADDI:      next_state = ADDIEXEC;
          OP_J:         next_state = JUMP;
          OP_BNE: begin
            if (BNE_EN) begin
              next_state = BRANCH;
            end else begin
              illegal_op = 1'b1;
              instr_done = 1'b1;
            end
          end
          default: begin
            illegal_op = 1'b1;
            instr_done = 1'b1;
          end
        endcase
      end
      MEMADR: begin
        alu_src_a  = 1'b1;
        alu_src_b  = 2'b10;
        next_state = (op_code == OP_SW) ? MEMWR : MEMRD;
      end
      MEMRD: begin
        i_or_d     = 1'b1;
        next_state = ready ? MEMWB : MEMRD;
      end
      MEMWR: begin
        i_or_d     = 1'b1;
        mem_w      = 1'b1;
        instr_done = ready;
        next_state = ready ? FETCH : MEMWR;
      end
      MEMWB: begin
        reg_w      = 1'b1;
        mem_to_reg = 1'b1;
        instr_done = 1'b1;
      end
      EXECUTE: begin
        alu_src_a  = 1'b1;
        alu_op     = 2'b10;
        next_state = ALUWB;
      end
      ALUWB: begin
        reg_w      = 1'b1;
        reg_dest   = 1'b1;
        instr_done = 1'b1;
      end
      BRANCH: begin
        alu_src_a  = 1'b1;
        alu_op     = 2'b01;
        pc_src     = 2'b01;
        pc_en      = op_is_bne ? ~zero : zero;
        instr_done = 1'b1;
      end
      ADDIEXEC: begin
        alu_src_a  = 1'b1;
        alu_src_b  = 2'b10;
        next_state = ADDIWB;
      end
      ADDIWB: begin
        reg_w      = 1'b1;
        instr_done = 1'b1;
      end
      JUMP: begin
        pc_src     = 2'b10;
        pc_en      = 1'b1;
        instr_done = 1'b1;
      end
      default: begin
        next_state = FETCH;
      end
    endcase

    if (rst) begin
      next_state = FETCH;
      ir_w       = 1'b0;
      pc_en      = 1'b0;
      i_or_d     = 1'b0;
      mem_w      = 1'b0;
      reg_w      = 1'b0;
      reg_dest   = 1'b0;
      mem_to_reg = 1'b0;
      alu_src_a  = 1'b0;
      alu_src_b  = 2'b00;
      pc_src     = 2'b00;
      alu_op     = 2'b00;
      instr_done = 1'b0;
      illegal_op = 1'b0;
    end
  end

endmodule
